// File: rtl/bp_ctrl.sv
// Port arbiter for the 2-bit branch-predictor counter table: fetcher lookups,
// queued ROB updates applied as saturating read-modify-writes, and a clear walk.
module bp_ctrl #(
    parameter int          TAG_W    = 8,
    parameter int          Q_DEPTH  = 4,
    parameter logic [1:0]  INIT_CNT = 2'b10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_fetcher_valid,
    input  logic [TAG_W-1:0] in_fetcher_tag,
    output logic             out_fetcher_grant,
    output logic             out_fetcher_jump_res,
    input  logic             in_rob_bp_res,
    input  logic [TAG_W-1:0] in_rob_tag,
    input  logic             in_rob_jump_res,
    input  logic             in_clear,
    output logic             out_busy,
    output logic [TAG_W-1:0] out_tbl_addr,
    output logic             out_tbl_we,
    output logic [1:0]       out_tbl_wdata,
    input  logic [1:0]       in_tbl_rdata
);

    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = $clog2(Q_DEPTH + 1);
    localparam logic [TAG_W-1:0] LAST_IDX = {TAG_W{1'b1}};
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Q_DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   idx_q, idx_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TAG_W-1:0]   fifo_tag_q [Q_DEPTH];
    logic [TAG_W-1:0]   fifo_tag_d [Q_DEPTH];
    logic               fifo_res_q [Q_DEPTH];
    logic               fifo_res_d [Q_DEPTH];

    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;

    // Two-bit saturating counter step toward the observed outcome.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    assign fifo_full_s  = (count_q == FULL_CNT);
    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});

    // Busy decodes the state register; reset forces it high during the reset cycle.
    always_comb begin
        out_busy = rst | (state_q == ST_CLEAR);
    end

    // Port arbitration, clear walk and FIFO bookkeeping for the next edge.
    always_comb begin
        state_d              = state_q;
        idx_d                = idx_q;
        head_d               = head_q;
        tail_d               = tail_q;
        count_d              = count_q;
        fifo_tag_d           = fifo_tag_q;
        fifo_res_d           = fifo_res_q;
        push_s               = 1'b0;
        pop_s                = 1'b0;
        out_tbl_addr         = {TAG_W{1'b0}};
        out_tbl_we           = 1'b0;
        out_tbl_wdata        = 2'b00;
        out_fetcher_grant    = 1'b0;
        out_fetcher_jump_res = 1'b0;

        if (rst) begin
            state_d = ST_CLEAR;
        end else if (!rdy) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    out_tbl_addr  = idx_q;
                    out_tbl_we    = 1'b1;
                    out_tbl_wdata = INIT_CNT;
                    idx_d         = idx_q + TAG_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
                ST_RUN: begin
                    // A full queue must drain first so a same-cycle commit is never dropped.
                    if (fifo_full_s || (!in_fetcher_valid && !fifo_empty_s)) begin
                        out_tbl_addr  = fifo_tag_q[head_q];
                        out_tbl_we    = 1'b1;
                        out_tbl_wdata = sat_step(in_tbl_rdata, fifo_res_q[head_q]);
                        pop_s         = 1'b1;
                    end else if (in_fetcher_valid) begin
                        out_tbl_addr         = in_fetcher_tag;
                        out_fetcher_grant    = 1'b1;
                        out_fetcher_jump_res = in_tbl_rdata[1];
                    end else begin
                        out_tbl_addr = {TAG_W{1'b0}};
                    end

                    push_s = in_rob_bp_res;

                    if (in_clear) begin
                        state_d = ST_CLEAR;
                        idx_d   = {TAG_W{1'b0}};
                        head_d  = {PTR_W{1'b0}};
                        tail_d  = {PTR_W{1'b0}};
                        count_d = {CNT_W{1'b0}};
                    end else begin
                        if (push_s) begin
                            fifo_tag_d[tail_q] = in_rob_tag;
                            fifo_res_d[tail_q] = in_rob_jump_res;
                            tail_d             = tail_q + PTR_W'(1);
                        end else begin
                            tail_d = tail_q;
                        end
                        if (pop_s) begin
                            head_d = head_q + PTR_W'(1);
                        end else begin
                            head_d = head_q;
                        end
                        case ({push_s, pop_s})
                            2'b10:   count_d = count_q + CNT_W'(1);
                            2'b01:   count_d = count_q - CNT_W'(1);
                            default: count_d = count_q;
                        endcase
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                    idx_d   = {TAG_W{1'b0}};
                end
            endcase
        end
    end

    // State, walk index and FIFO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            idx_q      <= {TAG_W{1'b0}};
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            fifo_tag_q <= '{default: {TAG_W{1'b0}}};
            fifo_res_q <= '{default: 1'b0};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fifo_tag_q <= fifo_tag_d;
            fifo_res_q <= fifo_res_d;
        end
    end

endmodule

// File: doc/bp_ctrl.md
Name: bp_ctrl

Overview:
Access controller for the 2-bit branch-predictor counter table. The table has a single port with combinational read and synchronous write. This block shares that port between fetcher lookups and ROB commit-time updates. Updates are buffered in a small FIFO and each one is applied as a same-cycle read-modify-write with a saturating counter. A clear sequencer walks the whole table to the weakly-taken value after reset and on request. It sits between fetcher, ROB and the table storage.

Parameters:
TAG_W, 8, table index width; the table holds 2^TAG_W entries.
Q_DEPTH, 4, update FIFO depth; must be a power of 2 and at least 2.
INIT_CNT, 2'b10, counter value written by the clear walk.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
rdy  in  1  global ready; when low, all state is frozen.
in_fetcher_valid  in  1  fetcher lookup request this cycle.
in_fetcher_tag  in  TAG_W  lookup index.
out_fetcher_grant  out  1  lookup served this cycle.
out_fetcher_jump_res  out  1  prediction (counter MSB); meaningful only when grant=1.
in_rob_bp_res  in  1  ROB commits a branch outcome this cycle.
in_rob_tag  in  TAG_W  index of the committed branch.
in_rob_jump_res  in  1  actual outcome; 1 = taken.
in_clear  in  1  pulse: request a full-table re-initialisation.
out_busy  out  1  clear walk in progress.
out_tbl_addr  out  TAG_W  table port address.
out_tbl_we  out  1  table write enable.
out_tbl_wdata  out  2  table write data.
in_tbl_rdata  in  2  table[out_tbl_addr], combinational.

Behaviour:
- FSM states:
  - CLEAR: walk the table.
  - RUN: normal operation.
- Reset:
  - state=CLEAR, walk idx=0, FIFO emptied (count=0, pointers=0).
  - Outputs: busy=1, grant=0, jump_res=0, tbl_we=0 during the reset cycle.
- CLEAR:
  - Each rdy cycle: tbl_addr=idx, tbl_we=1, tbl_wdata=INIT_CNT, then idx+1.
  - At idx=2^TAG_W-1 the write happens and the next state is RUN.
  - The walk takes exactly 2^TAG_W rdy cycles. busy=1 and grant=0 throughout.
  - ROB updates arriving during CLEAR are discarded and not queued.
- in_clear in RUN:
  - Next state is CLEAR with idx=0 and the FIFO flushed.
  - The port action for that cycle still completes as in RUN.
  - in_clear while already in CLEAR is ignored; the walk does not restart.
- RUN port arbitration, one access per cycle, decided combinationally:
  1. If the FIFO is full and nonempty, drain the FIFO head; grant=0.
  2. Else if in_fetcher_valid: tbl_addr=in_fetcher_tag, tbl_we=0, grant=1, jump_res=in_tbl_rdata[1].
  3. Else if the FIFO is nonempty: drain the FIFO head.
  4. Else idle: tbl_we=0, tbl_addr=0.
- Drain (read-modify-write):
  - tbl_addr=head.tag and tbl_we=1.
  - Taken: wdata=rdata+1, saturating at 2'b11.
  - Not taken: wdata=rdata-1, saturating at 2'b00.
  - The head is popped at the clock edge.
- Enqueue:
  - In RUN, in_rob_bp_res=1 pushes {tag, jump_res} at the edge.
  - Push and pop in the same cycle is legal; count is unchanged.
  - Push when full only happens together with a forced drain, so no update is ever lost in RUN.
  - An update is applied at the earliest 1 cycle after commit; no bypass into the same cycle.
- No forwarding: a lookup may see the pre-update counter while a matching update is still queued. This is accepted.
- Ordering: updates to the same tag are applied in commit order.
- rdy=0:
  - No state, pointer, count or idx change; ROB input is ignored.
  - tbl_we=0 and grant=0.
- All outputs except the tbl_* and fetcher combinational paths are registered state decodes. busy is a decode of the state register.

Test Plan:
- Reset, rdy=1, run 256 cycles -> 256 writes of 2'b10 to addr 0..255 in order; busy falls on cycle 257; lookup of tag 5 returns grant=1, jump_res=1.
- Commit three not-taken updates to tag 0x12 with fetcher idle -> table[0x12] goes 10->01->00->00 on consecutive cycles; a later lookup returns jump_res=0.
- Fetcher valid every cycle while 4 updates commit back-to-back -> FIFO reaches full and the next cycle drains with grant=0; fetcher is granted again once count drops below 4; all 4 updates are applied in order.
- Push and drain in the same cycle at count=4 -> count stays 4, no update is lost, and the final counters match a reference model.
- in_clear with 3 updates queued -> FIFO flushed, busy=1 next cycle, full 256-entry walk runs, and the queued updates are never written.
- Hold rdy=0 for 10 cycles mid-walk and mid-drain -> tbl_we=0 and idx/count are unchanged; the walk resumes at the same idx when rdy returns.
